imem_loadable: RTL

Parametrised, runtime-loadable instruction memory for the Redux-V core. It is the successor to the fixed-image instruction ROM. A program is streamed in word by word over a valid/ready load port, and the fetch stage then reads it through a registered, one-cycle-latency fetch port with bounds checking against the loaded program length. It sits between the program loader (testbench or boot logic) and the fetch stage of the datapath.

---
 rtl/imem_loadable.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/imem_loadable.sv
// -----------------------------------------------------------------------------
// imem_loadable
//
// Runtime-loadable instruction memory for the Redux-V core.
//
// A program loader streams words in over a valid/ready load port. After the
// last word (or when the memory is full) the block enters READY. The fetch
// stage can then read words through a registered fetch port with a latency of
// one cycle. Addresses at or above the loaded program length return a NOP
// (all zeros) and raise fetch_oob.
//
// Optional feature macro: IMEM_PARITY_EN
//   defined   : every stored word carries one even-parity bit; fetch_perr
//               reports a mismatch when the word is read back
//   undefined : no parity storage; fetch_perr is always 0
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   load_start    pulse: begin loading a new program at address 0
//   load_valid    load_data is valid this cycle
//   load_data     instruction word to store
//   load_last     marks the final word of the program
//   load_ready    a word is accepted this cycle (high only while loading)
//   load_done     one-cycle pulse when loading completes
//   prog_len      number of words in the loaded program (0..2**ADDR_W)
//   fetch_req     fetch request (served only when a program is loaded)
//   fetch_addr    fetch address
//   fetch_valid   instruction/fetch_oob/fetch_perr answer last cycle's request
//   instruction   fetched word (held while fetch_valid is 0)
//   fetch_oob     address was outside the loaded program
//   fetch_perr    parity mismatch on the fetched word
// -----------------------------------------------------------------------------
module imem_loadable #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic [ADDR_W:0]   prog_len,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] instruction,
  output logic              fetch_oob,
  output logic              fetch_perr
);

  localparam int DEPTH = 1 << ADDR_W;
`ifdef IMEM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  localparam logic [ADDR_W-1:0] WPTR_FULL = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [ADDR_W-1:0]   wptr_r;
  logic [ADDR_W:0]     prog_len_r;
  logic                load_ready_r;
  logic                load_done_r;
  logic                fetch_valid_r;
  logic [DATA_W-1:0]   instruction_r;
  logic                fetch_oob_r;
  logic                fetch_perr_r;

  logic                start_s;
  logic                accept_s;
  logic                exit_s;
  logic                fetch_go_s;
  logic [WORD_W-1:0]   wr_word_s;
  logic [WORD_W-1:0]   rd_word_s;
  logic                in_bounds_s;
  logic                perr_s;

  // Storage is deliberately not reset: contents survive rst but stay
  // unreachable until a new load completes.
  logic [WORD_W-1:0]   mem_r [DEPTH];

`ifdef IMEM_PARITY_EN
  // Even parity: the stored bit makes the total number of ones even.
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    even_parity = ^d;
  endfunction

  // A word read back with odd total parity has been corrupted.
  function automatic logic parity_error(input logic [WORD_W-1:0] w);
    parity_error = ^w;
  endfunction

  assign wr_word_s = {even_parity(load_data), load_data};
  assign perr_s    = parity_error(rd_word_s);
`else
  assign wr_word_s = load_data;
  assign perr_s    = 1'b0;
`endif

  assign rd_word_s   = mem_r[fetch_addr];
  // Compare at ADDR_W+1 bits so a full memory (prog_len = 2**ADDR_W) works.
  assign in_bounds_s = ({1'b0, fetch_addr} < prog_len_r);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_EMPTY, ST_READY: begin
        if (start_s) state_s = ST_LOAD;
        else         state_s = state_r;
      end
      ST_LOAD: begin
        if (exit_s) state_s = ST_READY;
        else        state_s = ST_LOAD;
      end
      default: state_s = ST_EMPTY;
    endcase
  end

  // FSM output decode: which actions happen on this edge.
  always_comb begin
    start_s    = 1'b0;
    accept_s   = 1'b0;
    exit_s     = 1'b0;
    fetch_go_s = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        start_s = load_start;
      end
      ST_LOAD: begin
        // load_start is ignored while loading; load_ready is 1 here.
        accept_s = load_valid;
        exit_s   = load_valid & (load_last | (wptr_r == WPTR_FULL));
      end
      ST_READY: begin
        start_s    = load_start;
        fetch_go_s = fetch_req;
      end
      default: begin
        start_s    = 1'b0;
        accept_s   = 1'b0;
        exit_s     = 1'b0;
        fetch_go_s = 1'b0;
      end
    endcase
  end

  // Load handshake outputs, registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_ready_r <= 1'b0;
      load_done_r  <= 1'b0;
    end else begin
      load_ready_r <= (state_s == ST_LOAD);
      load_done_r  <= exit_s;
    end
  end

  // Write pointer and program length bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_r     <= {ADDR_W{1'b0}};
      prog_len_r <= {(ADDR_W+1){1'b0}};
    end else if (start_s) begin
      wptr_r     <= {ADDR_W{1'b0}};
      prog_len_r <= {(ADDR_W+1){1'b0}};
    end else if (accept_s) begin
      // Wraps to 0 after a full load; harmless because LOAD is left then.
      wptr_r <= wptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      if (exit_s) begin
        prog_len_r <= {1'b0, wptr_r} + {{ADDR_W{1'b0}}, 1'b1};
      end
    end
  end

  // Memory write port.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_r[wptr_r] <= wr_word_s;
    end
  end

  // Registered fetch response; the data outputs hold when no fetch is served.
  // A fetch coinciding with load_start still sees the old contents/length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_valid_r <= 1'b0;
      instruction_r <= {DATA_W{1'b0}};
      fetch_oob_r   <= 1'b0;
      fetch_perr_r  <= 1'b0;
    end else if (fetch_go_s) begin
      fetch_valid_r <= 1'b1;
      if (in_bounds_s) begin
        instruction_r <= rd_word_s[DATA_W-1:0];
        fetch_oob_r   <= 1'b0;
        fetch_perr_r  <= perr_s;
      end else begin
        instruction_r <= {DATA_W{1'b0}};
        fetch_oob_r   <= 1'b1;
        fetch_perr_r  <= 1'b0;
      end
    end else begin
      fetch_valid_r <= 1'b0;
    end
  end

  assign load_ready  = load_ready_r;
  assign load_done   = load_done_r;
  assign prog_len    = prog_len_r;
  assign fetch_valid = fetch_valid_r;
  assign instruction = instruction_r;
  assign fetch_oob   = fetch_oob_r;
  assign fetch_perr  = fetch_perr_r;

endmodule
